// File: rtl/signed_accumulator.sv
// Signed frame accumulator: sums/subtracts operand beats until in_last, then holds the result for a handshake.
// Optional macro ACC_SAT_EN saturates the accumulator on overflow instead of wrapping.
module signed_accumulator #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sub,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count
);

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    accept;
  logic signed [WIDTH-1:0] operand;
  logic signed [WIDTH-1:0] sum;
  logic                    beat_ovf;

  // Largest magnitude of the same sign as the accumulator before the beat.
  function automatic logic signed [WIDTH-1:0] sat_value(input logic neg);
    sat_value = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Overflow judged on the operands actually fed to the adder, so subtracting the minimum is caught.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    add_ovf = (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

  assign accept   = in_valid & in_ready;
  assign operand  = in_sub ? ~in_data : in_data;
  assign sum      = acc_q + operand + {{(WIDTH-1){1'b0}}, in_sub};
  assign beat_ovf = add_ovf(acc_q[WIDTH-1], operand[WIDTH-1], sum[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
`ifdef ACC_SAT_EN
            acc_d = beat_ovf ? sat_value(acc_q[WIDTH-1]) : sum;
`else
            acc_d = sum;
`endif
            ovf_d = ovf_q | beat_ovf;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (in_last) begin
              state_d = ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC) & ~clear;
    out_valid = (state_q == ST_OUT);
  end

  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Directed bench for signed_accumulator at WIDTH=8, CNT_WIDTH=8; expectations follow ACC_SAT_EN when defined.
module tb_signed_accumulator;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_sub;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  int n_checks = 0;
  int n_pass   = 0;

  signed_accumulator #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives one beat just after an edge, lets the next edge take it, then idles the bus.
  task automatic beat(input logic [W-1:0] d, input logic sub, input logic last);
    in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0; in_data = '0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] d, input logic o, input logic [CW-1:0] c);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".data"},  out_data, d);
    check({tag, ".ovf"},   out_ovf, o);
    check({tag, ".count"}, out_count, c);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".released"}, out_valid, 0);
    check({tag, ".in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data",  out_data, 0);
    check("rst.out_ovf",   out_ovf, 0);
    check("rst.out_count", out_count, 0);
    check("rst.in_ready",  in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst.in_ready", in_ready, 1);

    // 5 + 3 - 2 = 6
    beat(8'd5, 0, 0);
    check("f1.mid_valid", out_valid, 0);
    beat(8'd3, 0, 0);
    beat(8'd2, 1, 1);
    check("f1.in_ready", in_ready, 0);
    check_result("f1", 8'd6, 0, 8'd3);
    take_result("f1");

    // 100 + 100 overflows positive
    beat(8'd100, 0, 0);
    beat(8'd100, 0, 1);
`ifdef ACC_SAT_EN
    check_result("f2", 8'd127, 1, 8'd2);
`else
    check_result("f2", 8'hC8, 1, 8'd2);
`endif
    take_result("f2");

    // -128 - 1 overflows negative
    beat(8'h80, 0, 0);
    beat(8'd1, 1, 1);
`ifdef ACC_SAT_EN
    check_result("f3", 8'h80, 1, 8'd2);
`else
    check_result("f3", 8'h7F, 1, 8'd2);
`endif
    take_result("f3");

    // 0 - (-128) overflows
    beat(8'd0, 0, 0);
    beat(8'h80, 1, 1);
`ifdef ACC_SAT_EN
    check_result("f4", 8'h7F, 1, 8'd2);
`else
    check_result("f4", 8'h80, 1, 8'd2);
`endif
    take_result("f4");

    // Held result with a pending beat on the input that must be ignored
    beat(8'd1, 0, 1);
    in_valid = 1'b1; in_data = 8'd50;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall.valid", out_valid, 1);
      check("stall.data", out_data, 1);
      check("stall.count", out_count, 1);
      check("stall.in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take_result("stall");
    check("stall.acc_zero", out_data, 0);
    check("stall.cnt_zero", out_count, 0);
    beat(8'd9, 0, 1);
    check_result("f5", 8'd9, 0, 8'd1);
    take_result("f5");

    // Clear mid-frame after an overflow, then a fresh one-beat frame
    beat(8'd100, 0, 0);
    beat(8'd100, 0, 0);
    clear = 1'b1;
    #1;
    check("clr.in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr.data", out_data, 0);
    check("clr.ovf", out_ovf, 0);
    check("clr.count", out_count, 0);
    beat(8'd7, 0, 1);
    check_result("f6", 8'd7, 0, 8'd1);

    // Clear while holding a result
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_out.valid", out_valid, 0);
    check("clr_out.count", out_count, 0);

    // Counter saturates at 255
    for (int i = 0; i < 299; i++) beat(8'd0, 0, 0);
    beat(8'd1, 0, 1);
    check_result("sat_cnt", 8'd1, 0, 8'd255);
    take_result("sat_cnt");

    // Async reset mid-frame discards the frame
    beat(8'd3, 0, 0);
    beat(8'd4, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.valid", out_valid, 0);
    check("rst_mid.data", out_data, 0);
    check("rst_mid.count", out_count, 0);
    check("rst_mid.in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid.no_result", out_valid, 0);

    // Async reset while holding a result
    beat(8'd5, 0, 1);
    check("rst_out.pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out.valid", out_valid, 0);
    check("rst_out.data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out.after", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
